// File: rtl/rob_multi_if.sv
`default_nettype none
// ============================================================================
// Interface : rob_multi_if
// Brief     : Issue, broadcast, operand-query and commit bundle of the
//             dual-commit reorder buffer.
// Revision  : 1.0 - initial release
// ============================================================================
interface rob_multi_if #(
  parameter int DEPTH_LOG = 4,
  parameter int XLEN      = 32
);
  // decoder / issue
  logic                 issue;
  logic [4:0]           issue_rd;
  logic [6:0]           issue_opcode;
  logic [XLEN-1:0]      issue_pc;
  logic                 issue_pred_jump;
  logic                 issue_is_ready;
  // ALU broadcast
  logic                 alu_result;
  logic [DEPTH_LOG-1:0] alu_result_rob_pos;
  logic [XLEN-1:0]      alu_result_val;
  logic                 alu_result_jump;
  logic [XLEN-1:0]      alu_result_pc;
  // load-store broadcast
  logic                 lsb_result;
  logic [DEPTH_LOG-1:0] lsb_result_rob_pos;
  logic [XLEN-1:0]      lsb_result_val;
  // operand query
  logic [DEPTH_LOG-1:0] rs1_pos;
  logic [DEPTH_LOG-1:0] rs2_pos;
  logic                 rs1_ready;
  logic                 rs2_ready;
  logic [XLEN-1:0]      rs1_val;
  logic [XLEN-1:0]      rs2_val;
  // occupancy
  logic [DEPTH_LOG-1:0] nxt_rob_pos;
  logic [DEPTH_LOG-1:0] head_rob_pos;
  logic [DEPTH_LOG:0]   rob_count;
  logic                 rob_nxt_full;
  // commit
  logic                 reg_write0;
  logic                 reg_write1;
  logic [4:0]           reg_rd0;
  logic [4:0]           reg_rd1;
  logic [XLEN-1:0]      reg_val0;
  logic [XLEN-1:0]      reg_val1;
  logic                 lsb_store;
  logic [DEPTH_LOG-1:0] commit_store_pos;
  logic                 commit_br;
  logic                 commit_br_jump;
  logic [XLEN-1:0]      commit_br_pc;
  logic                 rollback;
  logic                 if_set_pc_en;
  logic [XLEN-1:0]      if_set_pc;

  modport master (
    output issue, issue_rd, issue_opcode, issue_pc, issue_pred_jump, issue_is_ready,
    output alu_result, alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc,
    output lsb_result, lsb_result_rob_pos, lsb_result_val,
    output rs1_pos, rs2_pos,
    input  rs1_ready, rs2_ready, rs1_val, rs2_val,
    input  nxt_rob_pos, head_rob_pos, rob_count, rob_nxt_full,
    input  reg_write0, reg_write1, reg_rd0, reg_rd1, reg_val0, reg_val1,
    input  lsb_store, commit_store_pos, commit_br, commit_br_jump, commit_br_pc,
    input  rollback, if_set_pc_en, if_set_pc
  );

  modport slave (
    input  issue, issue_rd, issue_opcode, issue_pc, issue_pred_jump, issue_is_ready,
    input  alu_result, alu_result_rob_pos, alu_result_val, alu_result_jump, alu_result_pc,
    input  lsb_result, lsb_result_rob_pos, lsb_result_val,
    input  rs1_pos, rs2_pos,
    output rs1_ready, rs2_ready, rs1_val, rs2_val,
    output nxt_rob_pos, head_rob_pos, rob_count, rob_nxt_full,
    output reg_write0, reg_write1, reg_rd0, reg_rd1, reg_val0, reg_val1,
    output lsb_store, commit_store_pos, commit_br, commit_br_jump, commit_br_pc,
    output rollback, if_set_pc_en, if_set_pc
  );
endinterface
`default_nettype wire

// File: rtl/rob_multi.sv
`default_nettype none
// ============================================================================
// Module   : rob_multi
// Brief    : Parametrised reorder buffer with occupancy counter, up to two
//            in-order commits per cycle and flush after a mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module rob_multi #(
  parameter int DEPTH_LOG = 4,
  parameter int XLEN      = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   rdy,
  rob_multi_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG;

  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;

  typedef logic [DEPTH_LOG-1:0] pos_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;
  typedef logic [DEPTH_LOG+1:0] ext_t;

  // entry storage
  logic [DEPTH-1:0] r_ready, r_is_st, r_is_br, r_is_jr, r_pred, r_res_jump;
  logic [4:0]       r_rd     [DEPTH];
  logic [XLEN-1:0]  r_pc     [DEPTH];
  logic [XLEN-1:0]  r_val    [DEPTH];
  logic [XLEN-1:0]  r_res_pc [DEPTH];

  pos_t r_head, r_tail;
  cnt_t r_count;

  // registered commit outputs
  logic            r_reg_write0, r_reg_write1, r_lsb_store, r_commit_br, r_commit_br_jump;
  logic            r_rollback, r_if_set_pc_en;
  logic [4:0]      r_reg_rd0, r_reg_rd1;
  logic [XLEN-1:0] r_reg_val0, r_reg_val1, r_commit_br_pc, r_if_set_pc;
  pos_t            r_commit_store_pos;

  pos_t w_head1;
  logic w_mis0, w_mis1, w_c0, w_c1, w_do_issue;
  ext_t w_occ_nxt;

  assign w_head1 = r_head + pos_t'(1);
  assign w_mis0  = (r_is_br[r_head]  | r_is_jr[r_head])  & (r_pred[r_head]  != r_res_jump[r_head]);
  assign w_mis1  = (r_is_br[w_head1] | r_is_jr[w_head1]) & (r_pred[w_head1] != r_res_jump[w_head1]);

  // Slot 1 is only taken when it cannot conflict with slot 0: a mispredicted
  // head must be the last commit, and store/branch ports are single-issue.
  assign w_c0 = (r_count != '0) & r_ready[r_head];
  assign w_c1 = w_c0 & (r_count >= cnt_t'(2)) & r_ready[w_head1] & ~w_mis0
              & ~(r_is_st[r_head] & r_is_st[w_head1])
              & ~(r_is_br[r_head] & r_is_br[w_head1]);

  assign w_do_issue = bus.issue & (r_count != cnt_t'(DEPTH));
  assign w_occ_nxt  = ext_t'(r_count) + ext_t'(bus.issue) - ext_t'(w_c0) - ext_t'(w_c1);

  assign bus.rob_nxt_full = (w_occ_nxt == ext_t'(DEPTH));
  assign bus.nxt_rob_pos  = r_tail;
  assign bus.head_rob_pos = r_head;
  assign bus.rob_count    = r_count;
  assign bus.rs1_ready    = r_ready[bus.rs1_pos];
  assign bus.rs2_ready    = r_ready[bus.rs2_pos];
  assign bus.rs1_val      = r_val[bus.rs1_pos];
  assign bus.rs2_val      = r_val[bus.rs2_pos];

  assign bus.reg_write0       = r_reg_write0;
  assign bus.reg_write1       = r_reg_write1;
  assign bus.reg_rd0          = r_reg_rd0;
  assign bus.reg_rd1          = r_reg_rd1;
  assign bus.reg_val0         = r_reg_val0;
  assign bus.reg_val1         = r_reg_val1;
  assign bus.lsb_store        = r_lsb_store;
  assign bus.commit_store_pos = r_commit_store_pos;
  assign bus.commit_br        = r_commit_br;
  assign bus.commit_br_jump   = r_commit_br_jump;
  assign bus.commit_br_pc     = r_commit_br_pc;
  assign bus.rollback         = r_rollback;
  assign bus.if_set_pc_en     = r_if_set_pc_en;
  assign bus.if_set_pc        = r_if_set_pc;

  // Queue pointers, occupancy and entry contents; broadcasts land after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_ready    <= '0;
      r_is_st    <= '0;
      r_is_br    <= '0;
      r_is_jr    <= '0;
      r_pred     <= '0;
      r_res_jump <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]     <= '0;
        r_pc[i]     <= '0;
        r_val[i]    <= '0;
        r_res_pc[i] <= '0;
      end
    end else if (r_rollback) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= '0;
    end else if (rdy) begin
      if (w_do_issue) begin
        r_rd[r_tail]    <= bus.issue_rd;
        r_pc[r_tail]    <= bus.issue_pc;
        r_is_st[r_tail] <= (bus.issue_opcode == c_OP_STORE);
        r_is_br[r_tail] <= (bus.issue_opcode == c_OP_BRANCH);
        r_is_jr[r_tail] <= (bus.issue_opcode == c_OP_JALR);
        r_pred[r_tail]  <= bus.issue_pred_jump;
        r_ready[r_tail] <= bus.issue_is_ready;
        r_tail          <= r_tail + pos_t'(1);
      end
      if (bus.alu_result) begin
        r_val[bus.alu_result_rob_pos]      <= bus.alu_result_val;
        r_res_jump[bus.alu_result_rob_pos] <= bus.alu_result_jump;
        r_res_pc[bus.alu_result_rob_pos]   <= bus.alu_result_pc;
        r_ready[bus.alu_result_rob_pos]    <= 1'b1;
      end
      if (bus.lsb_result) begin
        r_val[bus.lsb_result_rob_pos]   <= bus.lsb_result_val;
        r_ready[bus.lsb_result_rob_pos] <= 1'b1;
      end
      r_head  <= w_c1 ? (r_head + pos_t'(2)) : (w_c0 ? w_head1 : r_head);
      r_count <= cnt_t'(r_count + cnt_t'(w_do_issue) - cnt_t'(w_c0) - cnt_t'(w_c1));
    end
  end

  // Commit outputs: pulses clear every enabled cycle, payloads hold last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write0       <= 1'b0;
      r_reg_write1       <= 1'b0;
      r_reg_rd0          <= '0;
      r_reg_rd1          <= '0;
      r_reg_val0         <= '0;
      r_reg_val1         <= '0;
      r_lsb_store        <= 1'b0;
      r_commit_store_pos <= '0;
      r_commit_br        <= 1'b0;
      r_commit_br_jump   <= 1'b0;
      r_commit_br_pc     <= '0;
      r_rollback         <= 1'b0;
      r_if_set_pc_en     <= 1'b0;
      r_if_set_pc        <= '0;
    end else if (r_rollback || rdy) begin
      r_reg_write0   <= 1'b0;
      r_reg_write1   <= 1'b0;
      r_lsb_store    <= 1'b0;
      r_commit_br    <= 1'b0;
      r_rollback     <= 1'b0;
      r_if_set_pc_en <= 1'b0;
      if (!r_rollback && w_c0) begin
        if (r_is_st[r_head]) begin
          r_lsb_store        <= 1'b1;
          r_commit_store_pos <= r_head;
        end else if (r_is_br[r_head]) begin
          r_commit_br      <= 1'b1;
          r_commit_br_jump <= r_res_jump[r_head];
          r_commit_br_pc   <= r_pc[r_head];
        end else begin
          r_reg_write0 <= 1'b1;
          r_reg_rd0    <= r_rd[r_head];
          r_reg_val0   <= r_val[r_head];
        end
        if (w_mis0) begin
          r_rollback     <= 1'b1;
          r_if_set_pc_en <= 1'b1;
          r_if_set_pc    <= r_res_pc[r_head];
        end
      end
      if (!r_rollback && w_c1) begin
        if (r_is_st[w_head1]) begin
          r_lsb_store        <= 1'b1;
          r_commit_store_pos <= w_head1;
        end else if (r_is_br[w_head1]) begin
          r_commit_br      <= 1'b1;
          r_commit_br_jump <= r_res_jump[w_head1];
          r_commit_br_pc   <= r_pc[w_head1];
        end else begin
          r_reg_write1 <= 1'b1;
          r_reg_rd1    <= r_rd[w_head1];
          r_reg_val1   <= r_val[w_head1];
        end
        if (w_mis1) begin
          r_rollback     <= 1'b1;
          r_if_set_pc_en <= 1'b1;
          r_if_set_pc    <= r_res_pc[w_head1];
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rob_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_multi
// Brief    : Directed self-checking bench for rob_multi (16-entry and
//            4-entry instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_multi;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [1:0] p4, h4;

  always #5 clk = ~clk;

  rob_multi_if #(.DEPTH_LOG(4), .XLEN(32)) bus16 ();
  rob_multi_if #(.DEPTH_LOG(2), .XLEN(32)) bus4 ();

  rob_multi #(.DEPTH_LOG(4), .XLEN(32)) u_dut16 (.clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus16));
  rob_multi #(.DEPTH_LOG(2), .XLEN(32)) u_dut4  (.clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    bus16.issue = 0; bus16.issue_rd = 0; bus16.issue_opcode = 0; bus16.issue_pc = 0;
    bus16.issue_pred_jump = 0; bus16.issue_is_ready = 0;
    bus16.alu_result = 0; bus16.alu_result_rob_pos = 0; bus16.alu_result_val = 0;
    bus16.alu_result_jump = 0; bus16.alu_result_pc = 0;
    bus16.lsb_result = 0; bus16.lsb_result_rob_pos = 0; bus16.lsb_result_val = 0;
  endtask

  task automatic idle4();
    bus4.issue = 0; bus4.issue_rd = 0; bus4.issue_opcode = 0; bus4.issue_pc = 0;
    bus4.issue_pred_jump = 0; bus4.issue_is_ready = 0;
    bus4.alu_result = 0; bus4.alu_result_rob_pos = 0; bus4.alu_result_val = 0;
    bus4.alu_result_jump = 0; bus4.alu_result_pc = 0;
    bus4.lsb_result = 0; bus4.lsb_result_rob_pos = 0; bus4.lsb_result_val = 0;
  endtask

  task automatic issue16(input logic [4:0] rd, input logic [6:0] op, input logic [31:0] pc,
                         input logic pred, input logic ready_at_issue);
    bus16.issue = 1; bus16.issue_rd = rd; bus16.issue_opcode = op; bus16.issue_pc = pc;
    bus16.issue_pred_jump = pred; bus16.issue_is_ready = ready_at_issue;
  endtask

  initial begin
    idle16(); idle4();
    bus16.rs1_pos = 0; bus16.rs2_pos = 0; bus4.rs1_pos = 0; bus4.rs2_pos = 0;
    rst_n = 0; rdy = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    step();
    // reset state
    chk("rst_count", bus16.rob_count, 0);
    chk("rst_tail", bus16.nxt_rob_pos, 0);
    chk("rst_head", bus16.head_rob_pos, 0);
    chk("rst_rollback", bus16.rollback, 0);
    chk("rst_set_pc_en", bus16.if_set_pc_en, 0);
    chk("rst_set_pc", bus16.if_set_pc, 0);
    chk("rst_full", bus16.rob_nxt_full, 0);

    // two ALU ops, dual commit
    issue16(5'd3, OP_ALU, 32'h100, 1'b0, 1'b0); step();
    chk("a_tail1", bus16.nxt_rob_pos, 1);
    chk("a_count1", bus16.rob_count, 1);
    issue16(5'd4, OP_ALU, 32'h104, 1'b0, 1'b0); step();
    idle16();
    bus16.alu_result = 1; bus16.alu_result_rob_pos = 0; bus16.alu_result_val = 32'h11;
    bus16.lsb_result = 1; bus16.lsb_result_rob_pos = 1; bus16.lsb_result_val = 32'h22;
    bus16.rs1_pos = 0; bus16.rs2_pos = 1; #1;
    chk("a_no_bypass", bus16.rs1_ready, 0);
    step(); idle16();
    chk("a_rs1_ready", bus16.rs1_ready, 1);
    chk("a_rs1_val", bus16.rs1_val, 32'h11);
    chk("a_rs2_val", bus16.rs2_val, 32'h22);
    chk("a_no_commit_yet", bus16.reg_write0, 0);
    chk("a_count2", bus16.rob_count, 2);
    step();
    chk("a_wr0", bus16.reg_write0, 1);
    chk("a_wr1", bus16.reg_write1, 1);
    chk("a_rd0", bus16.reg_rd0, 3);
    chk("a_rd1", bus16.reg_rd1, 4);
    chk("a_val0", bus16.reg_val0, 32'h11);
    chk("a_val1", bus16.reg_val1, 32'h22);
    chk("a_count0", bus16.rob_count, 0);
    chk("a_head2", bus16.head_rob_pos, 2);
    step();
    chk("a_wr0_pulse", bus16.reg_write0, 0);

    // adjacent stores commit one per cycle; rdy=0 freezes
    issue16(5'd0, OP_S, 32'h200, 1'b0, 1'b0); step();
    issue16(5'd0, OP_S, 32'h204, 1'b0, 1'b0); step();
    idle16();
    bus16.alu_result = 1; bus16.alu_result_rob_pos = 2; bus16.alu_result_val = 32'hAA;
    bus16.lsb_result = 1; bus16.lsb_result_rob_pos = 3; bus16.lsb_result_val = 32'hBB;
    step(); idle16();
    step();
    chk("st1_pulse", bus16.lsb_store, 1);
    chk("st1_pos", bus16.commit_store_pos, 2);
    chk("st1_count", bus16.rob_count, 1);
    chk("st1_no_wr", bus16.reg_write0, 0);
    rdy = 0; step();
    chk("frz_pulse", bus16.lsb_store, 1);
    chk("frz_count", bus16.rob_count, 1);
    chk("frz_head", bus16.head_rob_pos, 3);
    rdy = 1; step();
    chk("st2_pulse", bus16.lsb_store, 1);
    chk("st2_pos", bus16.commit_store_pos, 3);
    chk("st2_count", bus16.rob_count, 0);
    step();
    chk("st_pulse_clr", bus16.lsb_store, 0);

    // mispredicted branch at head with ready younger entry
    issue16(5'd7, OP_BR, 32'h300, 1'b0, 1'b0); step();
    issue16(5'd5, OP_ALU, 32'h304, 1'b0, 1'b1); step();
    idle16();
    bus16.alu_result = 1; bus16.alu_result_rob_pos = 4; bus16.alu_result_val = 0;
    bus16.alu_result_jump = 1; bus16.alu_result_pc = 32'h1000;
    step(); idle16();
    step();
    chk("br_commit", bus16.commit_br, 1);
    chk("br_jump", bus16.commit_br_jump, 1);
    chk("br_pc", bus16.commit_br_pc, 32'h300);
    chk("br_rollback", bus16.rollback, 1);
    chk("br_set_pc_en", bus16.if_set_pc_en, 1);
    chk("br_set_pc", bus16.if_set_pc, 32'h1000);
    chk("br_slot1_blocked", bus16.reg_write0, 0);
    chk("br_count", bus16.rob_count, 1);
    issue16(5'd9, OP_ALU, 32'h400, 1'b0, 1'b1);
    step(); idle16();
    chk("fl_count", bus16.rob_count, 0);
    chk("fl_rollback", bus16.rollback, 0);
    chk("fl_set_pc_en", bus16.if_set_pc_en, 0);
    chk("fl_commit_br", bus16.commit_br, 0);
    chk("fl_head", bus16.head_rob_pos, 0);
    chk("fl_tail", bus16.nxt_rob_pos, 0);
    chk("fl_wr0", bus16.reg_write0, 0);

    // fill to DEPTH
    for (int i = 0; i < 14; i++) begin
      issue16(5'(i), OP_ALU, 32'h500 + 32'(i), 1'b0, 1'b0); step();
    end
    issue16(5'd14, OP_ALU, 32'h600, 1'b0, 1'b0); #1;
    chk("full_at14", bus16.rob_nxt_full, 0);
    step();
    issue16(5'd15, OP_ALU, 32'h604, 1'b0, 1'b0); #1;
    chk("full_at15", bus16.rob_nxt_full, 1);
    chk("count15", bus16.rob_count, 15);
    step(); idle16(); #1;
    chk("count16", bus16.rob_count, 16);
    chk("full_at16", bus16.rob_nxt_full, 1);
    chk("tail_wrap", bus16.nxt_rob_pos, 0);
    issue16(5'd16, OP_ALU, 32'h608, 1'b0, 1'b0);
    step(); idle16();
    chk("ovf_count", bus16.rob_count, 16);
    chk("ovf_tail", bus16.nxt_rob_pos, 0);
    rst_n = 0; #2; rst_n = 1;
    step();

    // asynchronous reset with 5 live entries
    for (int i = 0; i < 5; i++) begin
      issue16(5'(10 + i), OP_ALU, 32'h700 + 32'(i), 1'b0, 1'b0); step();
    end
    idle16();
    bus16.alu_result = 1; bus16.alu_result_rob_pos = 0; bus16.alu_result_val = 32'h55;
    step(); idle16();
    bus16.rs1_pos = 0; #1;
    chk("mr_pre_ready", bus16.rs1_ready, 1);
    chk("mr_pre_val", bus16.rs1_val, 32'h55);
    chk("mr_pre_count", bus16.rob_count, 5);
    #1 rst_n = 0; #1;
    chk("mr_count", bus16.rob_count, 0);
    chk("mr_tail", bus16.nxt_rob_pos, 0);
    chk("mr_rs1_ready", bus16.rs1_ready, 0);
    chk("mr_rs1_val", bus16.rs1_val, 0);
    chk("mr_rollback", bus16.rollback, 0);
    @(negedge clk); rst_n = 1;
    step();
    chk("mr_count_after", bus16.rob_count, 0);

    // 4-entry instance: 12 issue/commit pairs with wrap-around
    for (int i = 0; i < 12; i++) begin
      p4 = 2'(i);
      h4 = p4 + 2'd1;
      bus4.issue = 1; bus4.issue_rd = 5'(i + 1); bus4.issue_opcode = OP_ALU;
      bus4.issue_pc = 32'h800 + 32'(4 * i); bus4.issue_pred_jump = 0; bus4.issue_is_ready = 0; #1;
      chk("w_tail", bus4.nxt_rob_pos, p4);
      step(); idle4();
      bus4.alu_result = 1; bus4.alu_result_rob_pos = p4; bus4.alu_result_val = 32'h100 + 32'(i);
      step(); idle4();
      step();
      chk("w_wr0", bus4.reg_write0, 1);
      chk("w_rd0", bus4.reg_rd0, 5'(i + 1));
      chk("w_val0", bus4.reg_val0, 32'h100 + 32'(i));
      chk("w_head", bus4.head_rob_pos, h4);
      chk("w_count", bus4.rob_count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
